// File: rtl/wbp2c_bridge.sv
// Pipelined-to-classic Wishbone bridge: one transaction in flight, with a bounded
// downstream wait, upstream abort on cyc drop, and reset release through a two-flop synchronizer.
module wbp2c_bridge #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                                   i_clk,
    input  logic                                   i_resetb,
    input  logic                                   i_wb_cyc,
    input  logic                                   i_wb_stb,
    input  logic                                   i_wb_we,
    input  logic [AW-1:0]                          i_wb_addr,
    input  logic [DW-1:0]                          i_wb_data,
    input  logic [((DW/8) > 0 ? (DW/8) : 1)-1:0]   i_wb_sel,
    output logic                                   o_wb_stall,
    output logic                                   o_wb_ack,
    output logic                                   o_wb_err,
    output logic [DW-1:0]                          o_wb_data,
    output logic                                   o_m_cyc,
    output logic                                   o_m_stb,
    output logic                                   o_m_we,
    output logic [AW-1:0]                          o_m_addr,
    output logic [DW-1:0]                          o_m_data,
    output logic [((DW/8) > 0 ? (DW/8) : 1)-1:0]   o_m_sel,
    input  logic                                   i_m_ack,
    input  logic                                   i_m_err,
    input  logic [DW-1:0]                          i_m_data
);

    localparam int SW = (DW/8) > 0 ? (DW/8) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t          r_state, w_state_nx;
    logic [1:0]      r_rst_sync;
    logic            w_rst_done;
    logic [15:0]     r_wait, w_wait_nx;
    logic            r_m_cyc, w_m_cyc_nx;
    logic            r_m_we, w_m_we_nx;
    logic [AW-1:0]   r_m_addr, w_m_addr_nx;
    logic [DW-1:0]   r_m_data, w_m_data_nx;
    logic [SW-1:0]   r_m_sel, w_m_sel_nx;
    logic            r_wb_ack, w_wb_ack_nx;
    logic            r_wb_err, w_wb_err_nx;
    logic [DW-1:0]   r_wb_data, w_wb_data_nx;
    logic            w_timeout;

    // Reset asserts asynchronously but releases only after two clean clock edges.
    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_done = r_rst_sync[1];

    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_m_cyc   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_data  <= '0;
            r_m_sel   <= '0;
            r_wb_ack  <= 1'b0;
            r_wb_err  <= 1'b0;
            r_wb_data <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_wait    <= w_wait_nx;
            r_m_cyc   <= w_m_cyc_nx;
            r_m_we    <= w_m_we_nx;
            r_m_addr  <= w_m_addr_nx;
            r_m_data  <= w_m_data_nx;
            r_m_sel   <= w_m_sel_nx;
            r_wb_ack  <= w_wb_ack_nx;
            r_wb_err  <= w_wb_err_nx;
            r_wb_data <= w_wb_data_nx;
        end
    end

    assign w_timeout = (r_wait == TO_LAST);

    // Termination priority in ACTIVE: abort, then err, then ack, then timeout.
    always_comb begin
        w_state_nx   = r_state;
        w_wait_nx    = r_wait;
        w_m_cyc_nx   = r_m_cyc;
        w_m_we_nx    = r_m_we;
        w_m_addr_nx  = r_m_addr;
        w_m_data_nx  = r_m_data;
        w_m_sel_nx   = r_m_sel;
        w_wb_ack_nx  = 1'b0;
        w_wb_err_nx  = 1'b0;
        w_wb_data_nx = r_wb_data;

        if (r_state == S_IDLE) begin
            if (w_rst_done && i_wb_cyc && i_wb_stb) begin
                w_state_nx  = S_ACTIVE;
                w_wait_nx   = '0;
                w_m_cyc_nx  = 1'b1;
                w_m_we_nx   = i_wb_we;
                w_m_addr_nx = i_wb_addr;
                w_m_data_nx = i_wb_data;
                w_m_sel_nx  = i_wb_sel;
            end
        end else begin
            w_wait_nx = r_wait + 16'd1;
            if (!i_wb_cyc) begin
                w_state_nx = S_IDLE;
                w_m_cyc_nx = 1'b0;
            end else if (i_m_err) begin
                w_state_nx  = S_IDLE;
                w_m_cyc_nx  = 1'b0;
                w_wb_err_nx = 1'b1;
            end else if (i_m_ack) begin
                w_state_nx  = S_IDLE;
                w_m_cyc_nx  = 1'b0;
                w_wb_ack_nx = 1'b1;
                if (!r_m_we) begin
                    w_wb_data_nx = i_m_data;
                end
            end else if (w_timeout) begin
                w_state_nx  = S_IDLE;
                w_m_cyc_nx  = 1'b0;
                w_wb_err_nx = 1'b1;
            end
        end
    end

    assign o_wb_stall = (r_state == S_ACTIVE);
    // Pulses are masked by the live cyc so a master that has already left the bus never sees them.
    assign o_wb_ack   = r_wb_ack & i_wb_cyc;
    assign o_wb_err   = r_wb_err & i_wb_cyc;
    assign o_wb_data  = r_wb_data;
    assign o_m_cyc    = r_m_cyc;
    assign o_m_stb    = r_m_cyc;
    assign o_m_we     = r_m_we;
    assign o_m_addr   = r_m_addr;
    assign o_m_data   = r_m_data;
    assign o_m_sel    = r_m_sel;

endmodule

// File: tb/tb_wbp2c_bridge.sv
// Directed bench for wbp2c_bridge: transaction-level timeline model checked every cycle,
// plus literal pins for the key scenarios.
module tb_wbp2c_bridge;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       wb_cyc, wb_stb, wb_we;
    logic [7:0] wb_addr, wb_data;
    logic [0:0] wb_sel;
    logic       wb_stall, wb_ack, wb_err;
    logic [7:0] wb_rdata;
    logic       m_cyc, m_stb, m_we;
    logic [7:0] m_addr, m_data;
    logic [0:0] m_sel;
    logic       m_ack, m_err;
    logic [7:0] m_rdata;

    int errors = 0;
    int checks = 0;

    // Expected outputs for the current cycle, and the model's persistent state.
    bit         e_valid;
    logic       e_stall, e_mcyc, e_ack, e_err, e_we;
    logic [7:0] e_addr, e_mdata, e_rdata;
    logic [0:0] e_sel;
    logic [7:0] rd_last;
    logic       p_ack, p_err;
    int         stall_cnt, term_cnt, mcyc_cnt;

    int b_ack[10] = '{1, 2, 3, 4, 0, 2, 1, 0, 3, 2};
    int b_err[10] = '{0, 0, 0, 0, 0, 2, 0, 3, 0, 0};

    always #5 clk = ~clk;

    wbp2c_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .i_clk      (clk),
        .i_resetb   (rstb),
        .i_wb_cyc   (wb_cyc),
        .i_wb_stb   (wb_stb),
        .i_wb_we    (wb_we),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_data),
        .i_wb_sel   (wb_sel),
        .o_wb_stall (wb_stall),
        .o_wb_ack   (wb_ack),
        .o_wb_err   (wb_err),
        .o_wb_data  (wb_rdata),
        .o_m_cyc    (m_cyc),
        .o_m_stb    (m_stb),
        .o_m_we     (m_we),
        .o_m_addr   (m_addr),
        .o_m_data   (m_data),
        .o_m_sel    (m_sel),
        .i_m_ack    (m_ack),
        .i_m_err    (m_err),
        .i_m_data   (m_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (e_valid) begin
            chk("stall",   32'(wb_stall), 32'(e_stall));
            chk("wb_ack",  32'(wb_ack),   32'(e_ack));
            chk("wb_err",  32'(wb_err),   32'(e_err));
            chk("wb_data", 32'(wb_rdata), 32'(e_rdata));
            chk("m_cyc",   32'(m_cyc),    32'(e_mcyc));
            chk("m_stb",   32'(m_stb),    32'(e_mcyc));
            if (e_mcyc) begin
                chk("m_we",   32'(m_we),   32'(e_we));
                chk("m_addr", 32'(m_addr), 32'(e_addr));
                chk("m_data", 32'(m_data), 32'(e_mdata));
                chk("m_sel",  32'(m_sel),  32'(e_sel));
            end
        end
        if (wb_stall) stall_cnt++;
        if (wb_ack || wb_err) term_cnt++;
        if (m_cyc) mcyc_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic ack_in);
        wb_cyc = 1'b1; wb_stb = 1'b0; m_ack = ack_in; m_err = 1'b0;
        e_valid = 1'b1; e_stall = 1'b0; e_mcyc = 1'b0;
        e_ack = p_ack; e_err = p_err; e_rdata = rd_last;
        p_ack = 1'b0; p_err = 1'b0;
        step();
        m_ack = 1'b0;
    endtask

    // Presents one request, answers it in ACTIVE cycle ack_at/err_at (0 = never), or drops
    // cyc in ACTIVE cycle abort_at; returns just after the terminating edge.
    task automatic run_txn(input logic we, input logic [7:0] addr, input logic [7:0] data,
                           input logic [7:0] rdata, input int ack_at, input int err_at,
                           input int abort_at, input bit hold);
        bit done;
        done = 1'b0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_data = data; wb_sel = 1'b1;
        m_ack = 1'b0; m_err = 1'b0;
        e_valid = 1'b1; e_stall = 1'b0; e_mcyc = 1'b0;
        e_ack = p_ack; e_err = p_err; e_rdata = rd_last;
        p_ack = 1'b0; p_err = 1'b0;
        e_we = we; e_addr = addr; e_mdata = data; e_sel = 1'b1;
        step();
        for (int k = 1; k <= TO; k++) begin
            e_stall = 1'b1; e_mcyc = 1'b1; e_ack = 1'b0; e_err = 1'b0; e_rdata = rd_last;
            wb_stb = hold;
            if (hold) begin
                wb_addr = ~addr; wb_data = ~data; wb_we = ~we;
            end
            m_ack   = (k == ack_at);
            m_err   = (k == err_at);
            wb_cyc  = (k != abort_at);
            m_rdata = (k == ack_at) ? rdata : ~rdata;
            if (k == abort_at) begin
                done = 1'b1;
            end else if (k == err_at) begin
                p_err = 1'b1; done = 1'b1;
            end else if (k == ack_at) begin
                p_ack = 1'b1; done = 1'b1;
                if (!we) rd_last = rdata;
            end else if (k == TO) begin
                p_err = 1'b1; done = 1'b1;
            end
            step();
            if (done) break;
        end
        m_ack = 1'b0; m_err = 1'b0; wb_cyc = 1'b1;
    endtask

    initial begin
        int s, t, m;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0; wb_sel = '0;
        m_ack = 1'b0; m_err = 1'b0; m_rdata = '0;
        e_valid = 1'b0; rd_last = '0; p_ack = 1'b0; p_err = 1'b0;
        e_stall = 1'b0; e_mcyc = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_we = 1'b0;
        e_addr = '0; e_mdata = '0; e_rdata = '0; e_sel = '0;
        stall_cnt = 0; term_cnt = 0; mcyc_cnt = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_cyc",   32'(m_cyc),    32'd0);
        chk("rst_m_addr",  32'(m_addr),   32'd0);
        chk("rst_wb_data", 32'(wb_rdata), 32'd0);
        chk("rst_stall",   32'(wb_stall), 32'd0);

        // Request presented in the first cycle after release must not be taken.
        rstb = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 8'hEE; wb_sel = 1'b1;
        e_valid = 1'b1;
        step();
        wb_stb = 1'b0;
        chk("early_accept", 32'(m_cyc), 32'd0);
        idle_cycle(1'b0); idle_cycle(1'b0); idle_cycle(1'b0);

        // Write, ack in the 3rd ACTIVE cycle.
        m = mcyc_cnt;
        run_txn(1'b1, 8'h12, 8'hA5, 8'h77, 3, 0, 0, 1'b0);
        chk("wr_ack",  32'(wb_ack),   32'd1);
        chk("wr_data", 32'(wb_rdata), 32'd0);
        idle_cycle(1'b0);
        chk("wr_active_cycles", 32'(mcyc_cnt - m), 32'd3);

        // Read, registered slave acking as soon as it can.
        s = stall_cnt;
        run_txn(1'b0, 8'h34, 8'h00, 8'h5C, 2, 0, 0, 1'b0);
        chk("rd_ack",  32'(wb_ack),   32'd1);
        chk("rd_data", 32'(wb_rdata), 32'h5C);
        idle_cycle(1'b0);
        chk("rd_stall_cycles", 32'(stall_cnt - s), 32'd2);

        // Timeout, then an immediate follow-up request.
        m = mcyc_cnt;
        run_txn(1'b0, 8'h56, 8'h00, 8'hAA, 0, 0, 0, 1'b0);
        chk("to_err",   32'(wb_err), 32'd1);
        chk("to_ack",   32'(wb_ack), 32'd0);
        chk("to_m_cyc", 32'(m_cyc),  32'd0);
        chk("to_active_cycles", 32'(mcyc_cnt - m), 32'd4);
        run_txn(1'b0, 8'h57, 8'h00, 8'h3C, 1, 0, 0, 1'b0);
        chk("after_to_data", 32'(wb_rdata), 32'h3C);
        idle_cycle(1'b0);

        // Abort in the 2nd ACTIVE cycle with a simultaneous ack.
        t = term_cnt;
        run_txn(1'b0, 8'h78, 8'h00, 8'h11, 2, 0, 2, 1'b0);
        idle_cycle(1'b0); idle_cycle(1'b0);
        chk("abort_no_term", 32'(term_cnt - t), 32'd0);
        chk("abort_data",    32'(wb_rdata),     32'h3C);

        // ack+err collision, then ack landing on the timeout cycle.
        run_txn(1'b0, 8'h9A, 8'h00, 8'h22, 2, 2, 0, 1'b0);
        chk("coll_err", 32'(wb_err), 32'd1);
        chk("coll_ack", 32'(wb_ack), 32'd0);
        idle_cycle(1'b0);
        run_txn(1'b0, 8'h9B, 8'h00, 8'h44, 4, 0, 0, 1'b0);
        chk("ack_on_to", 32'(wb_ack), 32'd1);
        idle_cycle(1'b0);

        // Downstream ack while idle is ignored.
        idle_cycle(1'b1); idle_cycle(1'b0);

        // Ten back-to-back requests, each stalled behind the previous one.
        t = term_cnt;
        for (int i = 0; i < 10; i++) begin
            run_txn(logic'(i % 2), 8'(8'h40 + i), 8'(8'h80 + i), 8'(8'hC0 + i),
                    b_ack[i], b_err[i], 0, (i != 9));
        end
        idle_cycle(1'b0);
        chk("b2b_terms", 32'(term_cnt - t), 32'd10);

        // Reset in the middle of a write.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 8'hE1; wb_data = 8'h5A; wb_sel = 1'b1;
        e_stall = 1'b0; e_mcyc = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_rdata = rd_last;
        e_we = 1'b1; e_addr = 8'hE1; e_mdata = 8'h5A; e_sel = 1'b1;
        step();
        wb_stb = 1'b0;
        e_stall = 1'b1; e_mcyc = 1'b1;
        step();
        #1;
        rstb = 1'b0;
        rd_last = '0;
        #1;
        chk("mrst_stall",  32'(wb_stall), 32'd0);
        chk("mrst_m_cyc",  32'(m_cyc),    32'd0);
        chk("mrst_m_stb",  32'(m_stb),    32'd0);
        chk("mrst_m_we",   32'(m_we),     32'd0);
        chk("mrst_m_addr", 32'(m_addr),   32'd0);
        chk("mrst_m_data", 32'(m_data),   32'd0);
        chk("mrst_m_sel",  32'(m_sel),    32'd0);
        chk("mrst_wbdata", 32'(wb_rdata), 32'd0);
        chk("mrst_ackerr", 32'(wb_ack | wb_err), 32'd0);
        e_stall = 1'b0; e_mcyc = 1'b0; e_rdata = '0;
        step();
        rstb = 1'b1;
        idle_cycle(1'b0); idle_cycle(1'b0); idle_cycle(1'b0);
        run_txn(1'b0, 8'hF0, 8'h00, 8'h99, 2, 0, 0, 1'b0);
        chk("post_rst_ack",  32'(wb_ack),   32'd1);
        chk("post_rst_data", 32'(wb_rdata), 32'h99);
        idle_cycle(1'b0);

        e_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
